// File: rtl/friscv_sv_pkg.sv
// Shared types and constants for the FRiscV run controller.
package friscv_sv_pkg;

  // Run-controller states.
  typedef enum logic [1:0] {
    TC_IDLE,
    TC_RESET_HOLD,
    TC_RUN,
    TC_DONE
  } tc_state_t;

  // tohost value that signals a passing test; any other value is a failure.
  localparam int TC_TOHOST_PASS = 1;

  // Bits needed to hold values 0..n, never less than one bit.
  function automatic int tc_cnt_width(input int n);
    int w;
    w = $clog2(n + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/friscv_sat_counter.sv
// Up-counter with synchronous clear and saturation at all-ones.
module friscv_sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Clear has priority over counting; the count sticks at all-ones.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && (count_q != {WIDTH{1'b1}})) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  // Count register, cleared by the system reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/friscv_test_controller.sv
// Run controller for the FRiscV core: holds the core in reset, releases it,
// watches dmem writes to the tohost word for a verdict and enforces a
// cycle-count watchdog. Every output comes straight from a flop.
module friscv_test_controller
  import friscv_sv_pkg::*;
#(
  parameter int                ADDR_W         = 32,
  parameter int                DATA_W         = 32,
  parameter int                CNT_W          = 32,
  parameter int                RESET_CYCLES   = 5,
  parameter int                TIMEOUT_CYCLES = 100000,
  parameter logic [ADDR_W-1:0] TOHOST_ADDR    = 32'h0000_1000,
  parameter int                AUTO_START     = 1,
  parameter int                HOLD_ON_DONE   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              dmem_we,
  input  logic [ADDR_W-1:0] dmem_addr,
  input  logic [DATA_W-1:0] dmem_wdata,
  output logic              core_rst_n,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              fail,
  output logic              timeout,
  output logic [DATA_W-1:0] exit_code,
  output logic [CNT_W-1:0]  cycle_count
);

  localparam int               HOLD_W       = tc_cnt_width(RESET_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LAST   = HOLD_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0]  TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam bit               WDOG_EN      = (TIMEOUT_CYCLES != 0);
  localparam bit               AUTO_EN      = (AUTO_START != 0);
  localparam bit               HOLD_DONE_EN = (HOLD_ON_DONE != 0);

  tc_state_t state_q;
  tc_state_t state_d;

  logic              core_rst_n_q, core_rst_n_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic              fail_q, fail_d;
  logic              timeout_q, timeout_d;
  logic [DATA_W-1:0] exit_code_q, exit_code_d;

  logic [HOLD_W-1:0] hold_cnt;
  logic [CNT_W-1:0]  run_cnt;
  logic              enter_hold;
  logic              in_run;
  logic              tohost_hit;
  logic              wdog_hit;

  assign in_run     = (state_q == TC_RUN);
  assign enter_hold = (state_d == TC_RESET_HOLD) && (state_q != TC_RESET_HOLD);
  assign tohost_hit = dmem_we && (dmem_addr == TOHOST_ADDR);
  assign wdog_hit   = WDOG_EN && (run_cnt == TIMEOUT_LAST);

  // Edges spent in RESET_HOLD; restarted on every entry.
  friscv_sat_counter #(.WIDTH(HOLD_W)) u_hold_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (enter_hold),
    .en    (state_q == TC_RESET_HOLD),
    .count (hold_cnt)
  );

  // Edges spent in RUN, including the edge that leaves RUN; frozen in DONE.
  friscv_sat_counter #(.WIDTH(CNT_W)) u_run_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (enter_hold),
    .en    (in_run),
    .count (run_cnt)
  );

  // State register; rst overrides every other input.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= TC_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. A tohost write and watchdog expiry both end the run.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      TC_IDLE: begin
        if (AUTO_EN || start) state_d = TC_RESET_HOLD;
      end
      TC_RESET_HOLD: begin
        if (hold_cnt == HOLD_LAST) state_d = TC_RUN;
      end
      TC_RUN: begin
        if (tohost_hit || wdog_hit) state_d = TC_DONE;
      end
      TC_DONE: begin
        if (start) state_d = TC_RESET_HOLD;
      end
      default: state_d = TC_IDLE;
    endcase
  end

  // Next values of the registered outputs. The tohost verdict beats the
  // watchdog when both land on the same edge.
  always_comb begin
    done_d      = done_q;
    pass_d      = pass_q;
    fail_d      = fail_q;
    timeout_d   = timeout_q;
    exit_code_d = exit_code_q;
    if (enter_hold) begin
      done_d      = 1'b0;
      pass_d      = 1'b0;
      fail_d      = 1'b0;
      timeout_d   = 1'b0;
      exit_code_d = '0;
    end else if (in_run && tohost_hit) begin
      done_d      = 1'b1;
      pass_d      = (dmem_wdata == DATA_W'(TC_TOHOST_PASS));
      fail_d      = (dmem_wdata != DATA_W'(TC_TOHOST_PASS));
      timeout_d   = 1'b0;
      exit_code_d = dmem_wdata >> 1;
    end else if (in_run && wdog_hit) begin
      done_d      = 1'b1;
      timeout_d   = 1'b1;
    end
    busy_d       = (state_d == TC_RESET_HOLD) || (state_d == TC_RUN);
    core_rst_n_d = (state_d == TC_RUN) || ((state_d == TC_DONE) && !HOLD_DONE_EN);
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      core_rst_n_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      fail_q       <= 1'b0;
      timeout_q    <= 1'b0;
      exit_code_q  <= '0;
    end else begin
      core_rst_n_q <= core_rst_n_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      fail_q       <= fail_d;
      timeout_q    <= timeout_d;
      exit_code_q  <= exit_code_d;
    end
  end

  assign core_rst_n  = core_rst_n_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign fail        = fail_q;
  assign timeout     = timeout_q;
  assign exit_code   = exit_code_q;
  assign cycle_count = run_cnt;

endmodule

// File: tb/tb_friscv_test_controller.sv
// Bench for friscv_test_controller: three instances (defaults, short watchdog,
// manual start) share the stimulus bus; each is exercised while the others
// are parked in reset.
module tb_friscv_test_controller;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a = 1'b1;
  logic        rst_b = 1'b1;
  logic        rst_c = 1'b1;
  logic        start = 1'b0;
  logic        dmem_we = 1'b0;
  logic [31:0] dmem_addr = 32'h0;
  logic [31:0] dmem_wdata = 32'h0;

  logic        a_core_rst_n, a_busy, a_done, a_pass, a_fail, a_timeout;
  logic [31:0] a_exit_code, a_cycle_count;
  logic        b_core_rst_n, b_busy, b_done, b_pass, b_fail, b_timeout;
  logic [31:0] b_exit_code, b_cycle_count;
  logic        c_core_rst_n, c_busy, c_done, c_pass, c_fail, c_timeout;
  logic [31:0] c_exit_code, c_cycle_count;

  friscv_test_controller u_a (
    .clk(clk), .rst(rst_a), .start(start), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .core_rst_n(a_core_rst_n), .busy(a_busy), .done(a_done), .pass(a_pass),
    .fail(a_fail), .timeout(a_timeout), .exit_code(a_exit_code),
    .cycle_count(a_cycle_count)
  );

  friscv_test_controller #(.TIMEOUT_CYCLES(10)) u_b (
    .clk(clk), .rst(rst_b), .start(start), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .core_rst_n(b_core_rst_n), .busy(b_busy), .done(b_done), .pass(b_pass),
    .fail(b_fail), .timeout(b_timeout), .exit_code(b_exit_code),
    .cycle_count(b_cycle_count)
  );

  friscv_test_controller #(.AUTO_START(0)) u_c (
    .clk(clk), .rst(rst_c), .start(start), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .core_rst_n(c_core_rst_n), .busy(c_busy), .done(c_done), .pass(c_pass),
    .fail(c_fail), .timeout(c_timeout), .exit_code(c_exit_code),
    .cycle_count(c_cycle_count)
  );

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_v(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic expect_status(input logic d, input logic p, input logic f,
                               input logic t, input logic [31:0] ec,
                               input logic [31:0] cc);
    expect_v({31'b0, d});
    expect_v({31'b0, p});
    expect_v({31'b0, f});
    expect_v({31'b0, t});
    expect_v(ec);
    expect_v(cc);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    total_cnt++;
    if (exp_q.size() == 0) begin
      $error("FAIL %s observed=%0h expected=<none queued>", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) pass_cnt++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, e);
    end
  endtask

  task automatic chk_status(input string tag, input logic d, input logic p,
                            input logic f, input logic t,
                            input logic [31:0] ec, input logic [31:0] cc);
    chk({tag, "_done"}, {31'b0, d});
    chk({tag, "_pass"}, {31'b0, p});
    chk({tag, "_fail"}, {31'b0, f});
    chk({tag, "_timeout"}, {31'b0, t});
    chk({tag, "_exit"}, ec);
    chk({tag, "_cnt"}, cc);
  endtask

  // ---------------- driver tasks ----------------
  task automatic tohost_write(input logic [31:0] addr, input logic [31:0] data);
    dmem_we    = 1'b1;
    dmem_addr  = addr;
    dmem_wdata = data;
    tick();
    dmem_we    = 1'b0;
    dmem_addr  = 32'h0;
    dmem_wdata = 32'h0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    // ===== instance A: default parameters =====
    repeat (3) tick();
    expect_v(0); expect_v(0); expect_status(0, 0, 0, 0, 0, 0);
    chk("a_rst_core_rst_n", {31'b0, a_core_rst_n});
    chk("a_rst_busy", {31'b0, a_busy});
    chk_status("a_rst", a_done, a_pass, a_fail, a_timeout, a_exit_code, a_cycle_count);

    rst_a = 1'b0;
    tick();  // leave IDLE
    expect_v(1); expect_v(0);
    chk("a_hold_busy", {31'b0, a_busy});
    chk("a_hold_core_rst_n", {31'b0, a_core_rst_n});
    for (int i = 1; i <= 5; i++) begin
      tick();
      expect_v((i == 5) ? 32'd1 : 32'd0);
      chk("a_hold_len", {31'b0, a_core_rst_n});
    end
    expect_v(0); expect_v(1);
    chk("a_run_cnt0", a_cycle_count);
    chk("a_run_busy", {31'b0, a_busy});
    tick();
    expect_v(1);
    chk("a_run_cnt1", a_cycle_count);
    repeat (18) tick();
    expect_v(19);
    chk("a_run_cnt19", a_cycle_count);

    tohost_write(32'h1000, 32'h1);
    expect_status(1, 1, 0, 0, 0, 20); expect_v(0); expect_v(0);
    chk_status("a_pass", a_done, a_pass, a_fail, a_timeout, a_exit_code, a_cycle_count);
    chk("a_pass_core_rst_n", {31'b0, a_core_rst_n});
    chk("a_pass_busy", {31'b0, a_busy});

    tohost_write(32'h1000, 32'h7);  // ignored in DONE
    tick();
    expect_status(1, 1, 0, 0, 0, 20);
    chk_status("a_done_hold", a_done, a_pass, a_fail, a_timeout, a_exit_code, a_cycle_count);

    pulse_start();  // restart from DONE
    expect_status(0, 0, 0, 0, 0, 0); expect_v(1); expect_v(0);
    chk_status("a_restart", a_done, a_pass, a_fail, a_timeout, a_exit_code, a_cycle_count);
    chk("a_restart_busy", {31'b0, a_busy});
    chk("a_restart_core_rst_n", {31'b0, a_core_rst_n});
    repeat (5) tick();
    expect_v(1);
    chk("a_rerun_core_rst_n", {31'b0, a_core_rst_n});
    tohost_write(32'h1000, 32'h7);
    expect_status(1, 0, 1, 0, 3, 1);
    chk_status("a_fail", a_done, a_pass, a_fail, a_timeout, a_exit_code, a_cycle_count);

    pulse_start();
    repeat (5) tick();
    repeat (7) tick();
    expect_v(7);
    chk("a_mid_cnt7", a_cycle_count);
    rst_a = 1'b1;
    tick();
    expect_v(0); expect_v(0); expect_status(0, 0, 0, 0, 0, 0);
    chk("a_midrst_core_rst_n", {31'b0, a_core_rst_n});
    chk("a_midrst_busy", {31'b0, a_busy});
    chk_status("a_midrst", a_done, a_pass, a_fail, a_timeout, a_exit_code, a_cycle_count);
    rst_a = 1'b0;
    tick();
    expect_v(1);
    chk("a_again_busy", {31'b0, a_busy});
    repeat (5) tick();
    expect_v(1);
    chk("a_again_core_rst_n", {31'b0, a_core_rst_n});
    tohost_write(32'h1004, 32'h1);  // not tohost
    repeat (3) tick();
    expect_status(0, 0, 0, 0, 0, 4); expect_v(1);
    chk_status("a_other_addr", a_done, a_pass, a_fail, a_timeout, a_exit_code, a_cycle_count);
    chk("a_other_busy", {31'b0, a_busy});
    rst_a = 1'b1;

    // ===== instance B: TIMEOUT_CYCLES = 10 =====
    rst_b = 1'b0;
    tick();
    repeat (5) tick();
    expect_v(1); expect_v(0);
    chk("b_run_core_rst_n", {31'b0, b_core_rst_n});
    chk("b_run_cnt0", b_cycle_count);
    repeat (9) tick();
    expect_v(9); expect_v(0);
    chk("b_cnt9", b_cycle_count);
    chk("b_cnt9_done", {31'b0, b_done});
    tick();
    expect_status(1, 0, 0, 1, 0, 10); expect_v(0);
    chk_status("b_wdog", b_done, b_pass, b_fail, b_timeout, b_exit_code, b_cycle_count);
    chk("b_wdog_busy", {31'b0, b_busy});

    pulse_start();
    repeat (5) tick();
    repeat (9) tick();
    expect_v(9);
    chk("b_re_cnt9", b_cycle_count);
    tohost_write(32'h1000, 32'h1);  // same edge as expiry
    expect_status(1, 1, 0, 0, 0, 10);
    chk_status("b_race", b_done, b_pass, b_fail, b_timeout, b_exit_code, b_cycle_count);
    rst_b = 1'b1;

    // ===== instance C: AUTO_START = 0 =====
    rst_c = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      expect_v(0);
      chk("c_idle_core_rst_n", {31'b0, c_core_rst_n});
    end
    expect_v(0);
    chk("c_idle_busy", {31'b0, c_busy});
    pulse_start();
    expect_v(1); expect_v(0);
    chk("c_start_busy", {31'b0, c_busy});
    chk("c_start_core_rst_n", {31'b0, c_core_rst_n});
    repeat (4) tick();
    expect_v(0);
    chk("c_hold4_core_rst_n", {31'b0, c_core_rst_n});
    tick();
    expect_v(1);
    chk("c_hold5_core_rst_n", {31'b0, c_core_rst_n});
    pulse_start();  // ignored in RUN
    expect_v(1); expect_v(1); expect_v(1);
    chk("c_runstart_busy", {31'b0, c_busy});
    chk("c_runstart_core_rst_n", {31'b0, c_core_rst_n});
    chk("c_runstart_cnt", c_cycle_count);
    repeat (2) tick();
    tohost_write(32'h1000, 32'h1);
    expect_status(1, 1, 0, 0, 0, 4);
    chk_status("c_pass", c_done, c_pass, c_fail, c_timeout, c_exit_code, c_cycle_count);
    pulse_start();
    expect_status(0, 0, 0, 0, 0, 0); expect_v(1); expect_v(0);
    chk_status("c_restart", c_done, c_pass, c_fail, c_timeout, c_exit_code, c_cycle_count);
    chk("c_restart_busy", {31'b0, c_busy});
    chk("c_restart_core_rst_n", {31'b0, c_core_rst_n});
    repeat (4) tick();
    expect_v(0);
    chk("c_rehold4_core_rst_n", {31'b0, c_core_rst_n});
    tick();
    expect_v(1); expect_v(0);
    chk("c_rehold5_core_rst_n", {31'b0, c_core_rst_n});
    chk("c_rerun_cnt0", c_cycle_count);
    rst_c = 1'b1;
    tick();

    if (exp_q.size() != 0) begin
      total_cnt++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
    end

    // ---------------- report ----------------
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/friscv_test_controller.md
Name: friscv_test_controller

Overview:
- Synthesisable run controller for the pipelined FRiscV core, instantiated beside friscv_fpga_wrapper in simulation and on FPGA.
- Generates the core's active-low reset with a parametrised hold length and supports auto-start or manual start/restart.
- Snoops data-memory writes to a tohost address to detect pass/fail and exit code.
- Enforces a cycle-count timeout watchdog and exposes a run cycle counter.

Parameters:
- ADDR_W, 32, dmem address width.
- DATA_W, 32, dmem write-data width.
- CNT_W, 32, cycle counter width.
- RESET_CYCLES, 5, core reset hold length in clk cycles; must be >= 1.
- TIMEOUT_CYCLES, 100000, run-cycle limit; 0 disables the watchdog.
- TOHOST_ADDR, 32'h0000_1000, tohost word address.
- AUTO_START, 1, 1 starts after rst without a start pulse.
- HOLD_ON_DONE, 1, 1 reasserts core reset while in DONE.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  single-cycle start/restart pulse
- dmem_we  in  1  core dmem write enable (snooped)
- dmem_addr  in  ADDR_W  core dmem write address
- dmem_wdata  in  DATA_W  core dmem write data
- core_rst_n  out  1  active-low reset to the core/wrapper
- busy  out  1  high in RESET_HOLD or RUN
- done  out  1  test finished (pass, fail or timeout)
- pass  out  1  tohost value == 1
- fail  out  1  tohost value != 1
- timeout  out  1  watchdog expired
- exit_code  out  DATA_W  tohost value >> 1
- cycle_count  out  CNT_W  clk cycles spent in RUN

Behaviour:
- Reset values, while rst = 1: state = IDLE, core_rst_n = 0, and busy, done, pass, fail, timeout, exit_code and cycle_count are all 0. rst is synchronous and active-high; it wins over every other input.
- All outputs are registered.
- States are IDLE, RESET_HOLD, RUN and DONE.
- IDLE -> RESET_HOLD:
  - when AUTO_START = 1, on the first edge with rst = 0;
  - otherwise on an edge with start = 1.
  - The entry edge clears the hold counter, cycle_count, done, pass, fail, timeout and exit_code.
- RESET_HOLD:
  - core_rst_n = 0.
  - After RESET_CYCLES edges in RESET_HOLD, go to RUN, with core_rst_n = 1 registered on the same edge.
  - dmem writes are ignored.
- RUN:
  - cycle_count increments every edge and saturates at all-ones.
  - On an edge with dmem_we = 1 and dmem_addr == TOHOST_ADDR, go to DONE and on the same edge set done = 1, pass = (dmem_wdata == 1), fail = !pass, exit_code = dmem_wdata >> 1.
  - Otherwise, if TIMEOUT_CYCLES != 0 and cycle_count == TIMEOUT_CYCLES - 1, go to DONE with done = 1 and timeout = 1; pass and fail stay 0.
  - If a tohost write and timeout occur on the same edge, the tohost write wins and timeout stays 0.
  - Writes to any other address have no effect.
- DONE:
  - done, pass, fail, timeout, exit_code and cycle_count hold their values.
  - core_rst_n = 0 if HOLD_ON_DONE = 1, else core_rst_n stays 1.
  - Later tohost writes are ignored.
  - start = 1 -> RESET_HOLD, a restart with cleared status.
- start in RESET_HOLD or RUN is ignored. start in IDLE when AUTO_START = 1 is harmless.
- rst asserted mid-RUN or mid-DONE returns to IDLE with reset values on the same edge; core_rst_n = 0 from the next cycle.
- busy = (state == RESET_HOLD) or (state == RUN).

Decomposition:
- In friscv_sv_pkg:
  - typedef enum logic [1:0] tc_state_t {TC_IDLE, TC_RESET_HOLD, TC_RUN, TC_DONE};
  - localparam TC_TOHOST_PASS = 1.
- One natural sub-module: friscv_sat_counter (width parameter, clear, enable, saturate). It is instantiated twice, once for the reset-hold count and once for cycle_count.

Test Plan:
- Defaults; rst high for 3 cycles, then low -> core_rst_n low for exactly 5 cycles after the IDLE exit, then high; busy = 1; cycle_count increments from 0.
- After 20 RUN cycles, write 32'h1 to 32'h1000 -> next cycle done = 1, pass = 1, fail = 0, exit_code = 0, cycle_count frozen at 20, core_rst_n = 0.
- Write 32'h7 to 32'h1000 -> fail = 1, pass = 0, exit_code = 3.
- TIMEOUT_CYCLES = 10, no tohost write -> done = 1 and timeout = 1 after 10 RUN cycles, cycle_count = 10. Same setup with a tohost write of 1 on the expiry edge -> pass = 1, timeout = 0.
- AUTO_START = 0: no start -> core_rst_n stays 0 for 100 cycles. start pulse -> normal sequence. start in DONE -> status cleared and reset hold repeats.
- rst pulse mid-RUN at cycle 7 -> outputs return to reset values. With AUTO_START = 1, the run sequence restarts, and a write to 32'h1004 never sets done.
